// File: rtl/background_control_pipeline.sv
// Background layer fetch/render: serial char/palette/tile fetch, 2bpp serial pixels from cycle 48 after lineStarting, fixed phase, no backpressure.
// Optional BGPIPE_TRANSPARENT_EN: colour index 0 always emits 2'b00.
module background_control_pipeline #(
   parameter int TILES_PER_LINE = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       lineStarting,
   input  logic [4:0] panOffset,
   output logic       charAddrOut,
   input  logic       charDataIn,
   output logic       palAddrOut,
   input  logic       palDataIn,
   output logic       tileLowAddrOut,
   output logic       tileHighAddrOut,
   input  logic       tileLowDataIn,
   input  logic       tileHighDataIn,
   output logic       pixelOut
);

   localparam logic [8:0] LAST_FETCH = 9'(TILES_PER_LINE);
   localparam logic [8:0] LAST_ATTR  = 9'(TILES_PER_LINE + 1);
   localparam logic [8:0] LAST_PIX   = 9'(TILES_PER_LINE + 2);

   logic       active, n_active;
   logic [8:0] slot, n_slot;
   logic [3:0] phase, n_phase;
   logic [1:0] coarse, n_coarse;
   logic [2:0] fine, n_fine;
   logic [7:0] char_sr, n_char_sr;
   logic [7:0] pal_sr, n_pal_sr, low_sr, n_low_sr, high_sr, n_high_sr;
   logic [7:0] cur_pal, n_cur_pal, cur_low, n_cur_low, cur_high, n_cur_high;
   logic [7:0] nxt_pal, n_nxt_pal, nxt_low, n_nxt_low, nxt_high, n_nxt_high;

   // State counters describe the cycle whose outputs are currently driven.
   always_comb begin
      n_active   = active;
      n_slot     = slot;
      n_phase    = phase;
      n_coarse   = coarse;
      n_fine     = fine;
      n_char_sr  = char_sr;
      n_pal_sr   = pal_sr;
      n_low_sr   = low_sr;
      n_high_sr  = high_sr;
      n_cur_pal  = cur_pal;
      n_cur_low  = cur_low;
      n_cur_high = cur_high;
      n_nxt_pal  = nxt_pal;
      n_nxt_low  = nxt_low;
      n_nxt_high = nxt_high;
      if (lineStarting) begin
         n_active   = 1'b1;
         n_slot     = 9'd0;
         n_phase    = 4'd0;
         n_coarse   = panOffset[4:3];
         n_fine     = panOffset[2:0];
         n_char_sr  = 8'd0;
         n_pal_sr   = 8'd0;
         n_low_sr   = 8'd0;
         n_high_sr  = 8'd0;
         n_cur_pal  = 8'd0;
         n_cur_low  = 8'd0;
         n_cur_high = 8'd0;
         n_nxt_pal  = 8'd0;
         n_nxt_low  = 8'd0;
         n_nxt_high = 8'd0;
      end else if (active) begin
         if (phase[3]) begin
            if (slot <= LAST_FETCH)
               n_char_sr = {char_sr[6:0], charDataIn};
            if (slot != 9'd0 && slot <= LAST_ATTR) begin
               n_pal_sr  = {pal_sr[6:0], palDataIn};
               n_low_sr  = {low_sr[6:0], tileLowDataIn};
               n_high_sr = {high_sr[6:0], tileHighDataIn};
               // Completed tile slides into the two-tile pixel window.
               if (phase == 4'd15) begin
                  n_cur_pal  = nxt_pal;
                  n_cur_low  = nxt_low;
                  n_cur_high = nxt_high;
                  n_nxt_pal  = n_pal_sr;
                  n_nxt_low  = n_low_sr;
                  n_nxt_high = n_high_sr;
               end
            end
         end
         n_phase = phase + 4'd1;
         if (phase == 4'd15) begin
            if (slot == LAST_PIX) begin
               n_active = 1'b0;
               n_slot   = 9'd0;
            end else begin
               n_slot = slot + 9'd1;
            end
         end
      end
   end

   logic [2:0] bit_sel;
   logic [7:0] char_addr;
   logic [3:0] q;
   logic [2:0] col;
   logic [7:0] src_pal, src_low, src_high, pal_shift;
   logic [1:0] cidx, entry;
   logic       n_char_out, n_attr_out, n_pix_out;

   always_comb begin
      bit_sel   = 3'd7 - n_phase[2:0];
      char_addr = n_slot[7:0] + {6'd0, n_coarse};
      q         = {1'b0, n_phase[3:1]} + {1'b0, n_fine};
      col       = 3'd7 - q[2:0];
      src_pal   = q[3] ? n_nxt_pal  : n_cur_pal;
      src_low   = q[3] ? n_nxt_low  : n_cur_low;
      src_high  = q[3] ? n_nxt_high : n_cur_high;
      cidx      = {src_high[col], src_low[col]};
      pal_shift = src_pal >> {cidx, 1'b0};
`ifdef BGPIPE_TRANSPARENT_EN
      entry     = (cidx == 2'd0) ? 2'b00 : pal_shift[1:0];
`else
      entry     = pal_shift[1:0];
`endif
      n_char_out = n_active && !n_phase[3] && (n_slot <= LAST_FETCH) && char_addr[bit_sel];
      n_attr_out = n_active && !n_phase[3] && (n_slot != 9'd0) && (n_slot <= LAST_ATTR)
                   && n_char_sr[bit_sel];
      n_pix_out  = n_active && (n_slot >= 9'd3) && (n_slot <= LAST_PIX)
                   && (n_phase[0] ? entry[0] : entry[1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active          <= 1'b0;
         slot            <= 9'd0;
         phase           <= 4'd0;
         coarse          <= 2'd0;
         fine            <= 3'd0;
         char_sr         <= 8'd0;
         pal_sr          <= 8'd0;
         low_sr          <= 8'd0;
         high_sr         <= 8'd0;
         cur_pal         <= 8'd0;
         cur_low         <= 8'd0;
         cur_high        <= 8'd0;
         nxt_pal         <= 8'd0;
         nxt_low         <= 8'd0;
         nxt_high        <= 8'd0;
         charAddrOut     <= 1'b0;
         palAddrOut      <= 1'b0;
         tileLowAddrOut  <= 1'b0;
         tileHighAddrOut <= 1'b0;
         pixelOut        <= 1'b0;
      end else begin
         active          <= n_active;
         slot            <= n_slot;
         phase           <= n_phase;
         coarse          <= n_coarse;
         fine            <= n_fine;
         char_sr         <= n_char_sr;
         pal_sr          <= n_pal_sr;
         low_sr          <= n_low_sr;
         high_sr         <= n_high_sr;
         cur_pal         <= n_cur_pal;
         cur_low         <= n_cur_low;
         cur_high        <= n_cur_high;
         nxt_pal         <= n_nxt_pal;
         nxt_low         <= n_nxt_low;
         nxt_high        <= n_nxt_high;
         charAddrOut     <= n_char_out;
         palAddrOut      <= n_attr_out;
         tileLowAddrOut  <= n_attr_out;
         tileHighAddrOut <= n_attr_out;
         pixelOut        <= n_pix_out;
      end
   end

endmodule

// File: tb/tb_background_control_pipeline.sv
// Bench for background_control_pipeline: memory responder model, queued expected serial windows, negedge monitor.
module tb_background_control_pipeline;
   localparam int T = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       lineStarting = 1'b0;
   logic [4:0] panOffset = 5'd0;
   logic       charAddrOut, palAddrOut, tileLowAddrOut, tileHighAddrOut, pixelOut;
   logic       charDataIn, palDataIn, tileLowDataIn, tileHighDataIn;

   background_control_pipeline #(.TILES_PER_LINE(T)) dut (
      .clk(clk), .rst_n(rst_n), .lineStarting(lineStarting), .panOffset(panOffset),
      .charAddrOut(charAddrOut), .charDataIn(charDataIn),
      .palAddrOut(palAddrOut), .palDataIn(palDataIn),
      .tileLowAddrOut(tileLowAddrOut), .tileHighAddrOut(tileHighAddrOut),
      .tileLowDataIn(tileLowDataIn), .tileHighDataIn(tileHighDataIn),
      .pixelOut(pixelOut)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          sig;
      int          line;
      int          start;
      int          len;
      logic [15:0] val;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          line_id = 0;
   logic [7:0]  char_mem [256];
   logic [7:0]  pal_mem  [256];
   logic [7:0]  low_mem  [256];
   logic [7:0]  high_mem [256];
   logic        bits [5][512];
   logic [7:0]  ca = 8'd0, pa = 8'd0, la = 8'd0, ha = 8'd0;
   logic [15:0] got;
   int          ph;

   function automatic string sig_name(input int s);
      case (s)
         0: return "charAddrOut";
         1: return "palAddrOut";
         2: return "tileLowAddrOut";
         3: return "tileHighAddrOut";
         default: return "pixelOut";
      endcase
   endfunction

   // Cycle index relative to the last sampled lineStarting.
   always @(posedge clk) begin
      if (lineStarting) begin
         cyc     <= 0;
         line_id <= line_id + 1;
      end else if (cyc < 100000) begin
         cyc <= cyc + 1;
      end
   end

   // Memory model: capture address bits in phases 0-7, return data in phases 8-15.
   always @(negedge clk) begin
      ph = cyc % 16;
      if (ph < 8) begin
         ca = {ca[6:0], charAddrOut};
         pa = {pa[6:0], palAddrOut};
         la = {la[6:0], tileLowAddrOut};
         ha = {ha[6:0], tileHighAddrOut};
         charDataIn = 1'b0;
         palDataIn = 1'b0;
         tileLowDataIn = 1'b0;
         tileHighDataIn = 1'b0;
      end else begin
         charDataIn     = char_mem[ca][15-ph];
         palDataIn      = pal_mem[pa][15-ph];
         tileLowDataIn  = low_mem[la][15-ph];
         tileHighDataIn = high_mem[ha][15-ph];
      end
   end

   // Monitor: record output bits and retire every expectation whose window has closed.
   always @(negedge clk) begin
      if (cyc < 512) begin
         bits[0][cyc] = charAddrOut;
         bits[1][cyc] = palAddrOut;
         bits[2][cyc] = tileLowAddrOut;
         bits[3][cyc] = tileHighAddrOut;
         bits[4][cyc] = pixelOut;
      end
      while (exp_q.size() > 0 && exp_q[0].line == line_id
             && exp_q[0].start + exp_q[0].len - 1 <= cyc) begin
         got = 16'd0;
         for (int i = 0; i < exp_q[0].len; i++)
            got = {got[14:0], bits[exp_q[0].sig][exp_q[0].start + i]};
         checks++;
         if (got !== exp_q[0].val) begin
            failures++;
            $display("FAIL %s line=%0d cycles=%0d..%0d got=%h expected=%h",
                     sig_name(exp_q[0].sig), exp_q[0].line, exp_q[0].start,
                     exp_q[0].start + exp_q[0].len - 1, got, exp_q[0].val);
         end
         void'(exp_q.pop_front());
      end
   end

   task automatic push(input int sig, input int line, input int start, input int len,
                       input logic [15:0] val);
      exp_t e;
      e.sig = sig; e.line = line; e.start = start; e.len = len; e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic push_slot_all(input int line, input int s, input logic [15:0] ch,
                                input logic [15:0] attr, input logic [15:0] pix);
      push(0, line, 16*s, 16, ch);
      push(1, line, 16*s, 16, attr);
      push(2, line, 16*s, 16, attr);
      push(3, line, 16*s, 16, attr);
      push(4, line, 16*s, 16, pix);
   endtask

   task automatic pulse(input logic [4:0] pan);
      lineStarting = 1'b1;
      panOffset = pan;
      @(negedge clk);
      lineStarting = 1'b0;
   endtask

   task automatic wait_cyc(input int target);
      int n = 0;
      while (cyc != target && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (cyc != target) begin
         checks++;
         failures++;
         $display("FAIL wait_cyc got=%0d expected=%0d", cyc, target);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d expected=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic set_mem(input logic [7:0] xor_mask, input logic [7:0] pal,
                          input logic [7:0] low, input logic [7:0] high);
      for (int a = 0; a < 256; a++) begin
         char_mem[a] = 8'(a) ^ xor_mask;
         pal_mem[a]  = pal;
         low_mem[a]  = low;
         high_mem[a] = high;
      end
   endtask

   logic [15:0] transp_exp;

   initial begin
      set_mem(8'h00, 8'hE4, 8'hAA, 8'hCC);

      // Outputs quiet while reset is held from power-up.
      for (int s = 0; s < 5; s++) push(s, 0, 2, 8, 16'h0000);
      wait_cyc(12);
      rst_n = 1'b1;
      drain();

      // Reset mid-line abandons the line; nothing until the next lineStarting.
      for (int w = 0; w < 10; w++)
         for (int s = 0; s < 5; s++) push(s, line_id + 1, 31 + 16*w, 16, 16'h0000);
      pulse(5'd0);
      wait_cyc(30);
      @(posedge clk);
      #2 rst_n = 1'b0;
      wait_cyc(36);
      rst_n = 1'b1;
      drain();

      // pan 0, index = column, palette E4, L=AA, H=CC: colours 3,2,1,0 repeating.
      for (int s = 0; s < 8; s++)
         push_slot_all(line_id + 1, s,
                       (s <= T) ? {8'(s), 8'h00} : 16'h0000,
                       (s >= 1 && s <= T+1) ? {8'(s-1), 8'h00} : 16'h0000,
                       (s >= 3 && s <= T+2) ? 16'hE4E4 : 16'h0000);
      @(negedge clk);
      pulse(5'd0);
      drain();

      // Coarse pan 2 with index = address ^ 0x30.
      set_mem(8'h30, 8'hE4, 8'hAA, 8'hCC);
      push(0, line_id + 1, 0, 16, 16'h0200);
      push(1, line_id + 1, 0, 16, 16'h0000);
      push(0, line_id + 1, 16, 16, 16'h0300);
      push(1, line_id + 1, 16, 16, 16'h3200);
      push(2, line_id + 1, 16, 16, 16'h3200);
      push(1, line_id + 1, 32, 16, 16'h3300);
      pulse(5'b10_000);
      drain();

      // Fine pan 3 across tile boundaries.
      set_mem(8'h00, 8'hE4, 8'h00, 8'h00);
      low_mem[0] = 8'hFF;
      high_mem[2] = 8'hFF;
      push(4, line_id + 1, 48, 16, 16'h5540);
      push(4, line_id + 1, 64, 16, 16'h002A);
      pulse(5'b00_011);
      drain();

      // Restart at cycle 20 with a new coarse pan.
      set_mem(8'h00, 8'hE4, 8'hAA, 8'hCC);
      push(0, line_id + 1, 0, 16, 16'h0000);
      pulse(5'd0);
      wait_cyc(19);
      push(0, line_id + 1, 0, 16, 16'h0300);
      push(0, line_id + 1, 16, 16, 16'h0400);
      push(1, line_id + 1, 16, 16, 16'h0300);
      push(4, line_id + 1, 48, 16, 16'hE4E4);
      pulse(5'b11_000);
      drain();

      // Colour index 0 with palette FF.
`ifdef BGPIPE_TRANSPARENT_EN
      transp_exp = 16'h0000;
`else
      transp_exp = 16'hFFFF;
`endif
      set_mem(8'h00, 8'hFF, 8'h00, 8'h00);
      push(4, line_id + 1, 32, 16, 16'h0000);
      for (int s = 3; s <= T+2; s++) push(4, line_id + 1, 16*s, 16, transp_exp);
      push(4, line_id + 1, 16*(T+3), 16, 16'h0000);
      pulse(5'd0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
